// File: rtl/pipelined_power_unit_if.sv
// Handshake/operand bundle for pipelined_power_unit.
//   start    : request from the master, sampled by the unit only when not busy
//   base/exp : operands captured together with an accepted start
//   busy     : unit is stepping through exponent bits
//   done     : one-cycle pulse, result/overflow are valid from this cycle on
//   result   : base^exp mod 2^OUT_W, held until the next done
//   overflow : true power did not fit in OUT_W bits, held with result
interface pipelined_power_unit_if #(
   parameter int IN_W  = 8,
   parameter int EXP_W = 4,
   parameter int OUT_W = 32
) ();
   logic             start;
   logic [IN_W-1:0]  base;
   logic [EXP_W-1:0] exp;
   logic             busy;
   logic             done;
   logic [OUT_W-1:0] result;
   logic             overflow;

   modport master (
      output start, base, exp,
      input  busy, done, result, overflow
   );

   modport slave (
      input  start, base, exp,
      output busy, done, result, overflow
   );
endinterface

// File: rtl/pipelined_power_unit.sv
// Sequential power unit: result = base^exp using left-to-right binary
// exponentiation, one exponent bit per clock (always EXP_W steps).
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, wins over start
//   bus : slave side of pipelined_power_unit_if (start/base/exp in,
//         busy/done/result/overflow out)
module pipelined_power_unit #(
   parameter int IN_W  = 8,
   parameter int EXP_W = 4,
   parameter int OUT_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   pipelined_power_unit_if.slave  bus
);

   localparam int CNT_W = $clog2(EXP_W + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IN_W-1:0]  base_q, base_d;
   logic [EXP_W-1:0] exp_q, exp_d;
   logic [OUT_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OUT_W-1:0] result_q, result_d;
   logic             overflow_q, overflow_d;
   logic [OUT_W:0]   step;

   // One exponentiation step: square, optionally multiply by base.
   // Returns {discarded-bits-nonzero, truncated accumulator}.
   function automatic logic [OUT_W:0] pow_step(
      input logic [OUT_W-1:0] acc,
      input logic [IN_W-1:0]  b,
      input logic             mul
   );
      logic [2*OUT_W-1:0]    sq;
      logic [OUT_W+IN_W-1:0] p;
      logic                  ov;
      sq = {{OUT_W{1'b0}}, acc} * {{OUT_W{1'b0}}, acc};
      ov = |sq[2*OUT_W-1:OUT_W];
      p  = {{IN_W{1'b0}}, sq[OUT_W-1:0]} * {{OUT_W{1'b0}}, b};
      if (mul) begin
         ov = ov | (|p[OUT_W+IN_W-1:OUT_W]);
         return {ov, p[OUT_W-1:0]};
      end
      return {ov, sq[OUT_W-1:0]};
   endfunction

   // exp_q is shifted left each step, so its MSB is always the current bit
   assign step = pow_step(acc_q, base_q, exp_q[EXP_W-1]);

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      exp_d      = exp_q;
      acc_d      = acc_q;
      ovf_d      = ovf_q;
      cnt_d      = cnt_q;
      result_d   = result_q;
      overflow_d = overflow_q;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               base_d  = bus.base;
               exp_d   = bus.exp;
               acc_d   = OUT_W'(1);
               ovf_d   = 1'b0;
               cnt_d   = CNT_W'(EXP_W);
               state_d = RUN;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            acc_d = step[OUT_W-1:0];
            ovf_d = ovf_q | step[OUT_W];
            exp_d = exp_q << 1;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d    = DONE;
               result_d   = step[OUT_W-1:0];
               overflow_d = ovf_q | step[OUT_W];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and observable state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         ovf_q      <= 1'b0;
         cnt_q      <= '0;
         result_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         ovf_q      <= ovf_d;
         cnt_q      <= cnt_d;
         result_q   <= result_d;
         overflow_q <= overflow_d;
      end
   end

   // Operand registers are only meaningful after an accepted start
   always_ff @(posedge clk) begin
      base_q <= base_d;
      exp_q  <= exp_d;
   end

   assign bus.busy     = (state_q == RUN);
   assign bus.done     = (state_q == DONE);
   assign bus.result   = result_q;
   assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_pipelined_power_unit.sv
// Scoreboard bench for pipelined_power_unit: the stimulus process pushes the
// expected result, overflow and done cycle for every accepted start; a
// monitor pops and compares on every done pulse.
module tb_pipelined_power_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   pipelined_power_unit_if bus ();

   pipelined_power_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      logic        ovf;
      int          due;
   } exp_t;

   exp_t sb[$];

   int n_main = 0, bad_main = 0;
   int n_mon  = 0, bad_mon  = 0;

   // Monitor: compare every done pulse against the oldest expectation
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         n_mon = n_mon + 1;
         if (sb.size() == 0) begin
            bad_mon = bad_mon + 1;
            $display("FAIL unexpected_done: done=1 at cycle %0d, no operation pending", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (bus.result !== e.res) begin
               bad_mon = bad_mon + 1;
               $display("FAIL result: got %0d expected %0d", bus.result, e.res);
            end
            n_mon = n_mon + 1;
            if (bus.overflow !== e.ovf) begin
               bad_mon = bad_mon + 1;
               $display("FAIL overflow: got %0b expected %0b (result %0d)", bus.overflow, e.ovf, e.res);
            end
            n_mon = n_mon + 1;
            if (cyc != e.due) begin
               bad_mon = bad_mon + 1;
               $display("FAIL done_cycle: got %0d expected %0d (result %0d)", cyc, e.due, e.res);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_main = n_main + 1;
      if (act !== want) begin
         bad_main = bad_main + 1;
         $display("FAIL %s: got %0d expected %0d", name, act, want);
      end
   endtask

   // Drive start for one edge; optionally record the expected outcome.
   task automatic issue(input logic [7:0] b, input logic [3:0] e, input bit push,
                        input logic [31:0] res, input logic ovf);
      exp_t x;
      bus.start = 1'b1;
      bus.base  = b;
      bus.exp   = e;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (push) begin
         x.res = res;
         x.ovf = ovf;
         x.due = cyc + 4;
         sb.push_back(x);
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !bus.busy && !bus.done) break;
      end
      chk("drain_timeout", sb.size(), 0);
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.done) begin
            ok = 1'b1;
            break;
         end
      end
      chk("done_timeout", {31'd0, ok}, 1);
   endtask

   initial begin
      bit ok;
      bus.start = 1'b0;
      bus.base  = '0;
      bus.exp   = '0;

      // reset state
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", {31'd0, bus.busy}, 0);
      chk("rst_done", {31'd0, bus.done}, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_overflow", {31'd0, bus.overflow}, 0);

      // 1: latency and handshake timing, 5^2 then 6^2
      @(negedge clk);
      issue(8'd5, 4'd2, 1, 32'd25, 1'b0);
      for (int j = 1; j <= 4; j++) begin
         @(negedge clk);
         chk("t1_busy_run", {31'd0, bus.busy}, 1);
         chk("t1_done_run", {31'd0, bus.done}, 0);
      end
      @(negedge clk);
      chk("t1_busy_done", {31'd0, bus.busy}, 0);
      chk("t1_done_pulse", {31'd0, bus.done}, 1);
      @(negedge clk);
      chk("t1_done_cleared", {31'd0, bus.done}, 0);
      chk("t1_result_held", bus.result, 25);
      wait_idle();
      @(negedge clk);
      issue(8'd6, 4'd2, 1, 32'd36, 1'b0);
      wait_idle();

      // 2: large exponent and largest non-overflowing 255^4
      @(negedge clk);
      issue(8'd3, 4'd15, 1, 32'd14348907, 1'b0);
      wait_idle();
      @(negedge clk);
      issue(8'd255, 4'd4, 1, 32'd4228250625, 1'b0);
      wait_idle();

      // 3: overflow, modular result
      @(negedge clk);
      issue(8'd255, 4'd5, 1, 32'd167118079, 1'b1);
      wait_idle();
      chk("t3_overflow_held", {31'd0, bus.overflow}, 1);

      // 4: zero/one edge cases
      @(negedge clk);
      issue(8'd0, 4'd0, 1, 32'd1, 1'b0);
      wait_idle();
      @(negedge clk);
      issue(8'd0, 4'd7, 1, 32'd0, 1'b0);
      wait_idle();
      @(negedge clk);
      issue(8'd1, 4'd15, 1, 32'd1, 1'b0);
      wait_idle();

      // 5: start during RUN ignored, back-to-back start in done cycle
      @(negedge clk);
      issue(8'd2, 4'd10, 1, 32'd1024, 1'b0);
      @(negedge clk);
      issue(8'd9, 4'd9, 0, 32'd0, 1'b0);
      wait_done(ok);
      chk("t5_result_1024", bus.result, 1024);
      issue(8'd2, 4'd3, 1, 32'd8, 1'b0);
      @(negedge clk);
      chk("t5_busy_b2b", {31'd0, bus.busy}, 1);
      chk("t5_hold_1024", bus.result, 1024);
      @(negedge clk);
      chk("t5_hold_1024_late", bus.result, 1024);
      wait_idle();

      // 6: reset aborts a running operation
      @(negedge clk);
      issue(8'd7, 4'd9, 0, 32'd0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("t6_busy", {31'd0, bus.busy}, 0);
      chk("t6_done", {31'd0, bus.done}, 0);
      chk("t6_result", bus.result, 0);
      chk("t6_overflow", {31'd0, bus.overflow}, 0);
      repeat (6) @(negedge clk);
      chk("t6_no_done", {31'd0, bus.done}, 0);
      issue(8'd7, 4'd9, 1, 32'd40353607, 1'b0);
      wait_idle();

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", n_main + n_mon, bad_main + bad_mon);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
